// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit that holds the architectural HI/LO registers.
// Each operation takes 33 cycles at one bit per cycle; new requests are not accepted while busy.
module mips_muldiv (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [31:0] opnd_b;
  logic [31:0] dividend_raw;
  logic [5:0]  cnt;
  logic        is_div;
  logic        div_zero;
  logic        neg_q;
  logic        neg_r;

  logic        sgn_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic [63:0] step_next;
  logic [63:0] prod;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    sgn_op = ~op[0];
    abs_a  = (sgn_op && read_data_1[31]) ? -read_data_1 : read_data_1;
    abs_b  = (sgn_op && read_data_2[31]) ? -read_data_2 : read_data_2;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    rem_sh  = acc[63:31];
    rem_sub = rem_sh - {1'b0, opnd_b};
    if (is_div)
      step_next = rem_sub[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                              : {rem_sub[31:0], acc[30:0], 1'b1};
    else
      step_next = {mul_sum, acc[31:1]};

    prod     = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      acc          <= 64'd0;
      opnd_b       <= 32'd0;
      dividend_raw <= 32'd0;
      cnt          <= 6'd0;
      is_div       <= 1'b0;
      div_zero     <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div       <= op[1];
            div_zero     <= op[1] && (read_data_2 == 32'd0);
            neg_q        <= sgn_op && (read_data_1[31] ^ read_data_2[31]);
            neg_r        <= sgn_op && op[1] && read_data_1[31];
            acc          <= {32'd0, abs_a};
            opnd_b       <= abs_b;
            dividend_raw <= read_data_1;
            cnt          <= 6'd0;
            busy         <= 1'b1;
            state        <= CALC;
          end else begin
            // MTHI/MTLO only take effect when no operation is being started
            if (hi_we) hi <= write_data;
            if (lo_we) lo <= write_data;
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (div_zero) begin
            hi          <= dividend_raw;
            lo          <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected {div_by_zero,hi,lo} queued at issue, checked on done.
module tb_mips_muldiv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] read_data_1 = 32'd0;
  logic [31:0] read_data_2 = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_exp;

  mips_muldiv dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: hi=%h lo=%h with nothing pending", hi, lo);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({div_by_zero, hi, lo} !== mon_exp) begin
            errors++;
            $display("FAIL result: got dbz=%0d hi=%h lo=%h, want dbz=%0d hi=%h lo=%h",
                     div_by_zero, hi, lo, mon_exp[64], mon_exp[63:32], mon_exp[31:0]);
          end
        end
      end else if (div_by_zero !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL dbz_without_done: div_by_zero=%0d, want 0", div_by_zero);
      end
    end
  end

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin q = sa * sb; return {1'b0, q[63:0]}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          return {1'b0, r[31:0], q[31:0]};
        end
        uq = ua / ub; ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Drives start for one edge; returns just after the accepting edge with operands scrambled.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [64:0] exp, input bit push);
    op = o; read_data_1 = a; read_data_2 = b; start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clock); #1;
    start = 1'b0; read_data_1 = $urandom; read_data_2 = $urandom;
  endtask

  // n = negedges until done seen (-1 on timeout); nbusy = negedges with busy high.
  task automatic wait_done(output int n, output int nbusy, output bit hl_changed);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    n = 0; nbusy = 0; hl_changed = 1'b0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      if (busy) nbusy++;
      if (done) break;
      if (hi !== h0 || lo !== l0) hl_changed = 1'b1;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%0d done=%0d dbz=%0d, want 0 0 0", busy, done, div_by_zero);
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_multu;
    int n, nb; bit ch;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL multu_latency: done after %0d edges, want 33", n - 1); end
    checks++;
    if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles: %0d, want 33", nb); end
    checks++;
    if (ch) begin errors++; $display("FAIL multu_hilo_stable: hi/lo changed while busy, want unchanged"); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%0d one cycle later, want 0", done); end
  endtask

  task automatic test_mult_div;
    int n, nb; bit ch;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL mult_latency: %0d edges, want 33", n - 1); end
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL div_latency: %0d edges, want 33", n - 1); end
  endtask

  task automatic test_div_zero;
    int n, nb; bit ch;
    issue(2'b11, 32'd100, 32'd0, {1'b1, 32'd100, 32'hFFFF_FFFF}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL divz_latency: %0d edges, want 33", n - 1); end
    @(negedge clock);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divz_pulse: dbz=%0d after done cycle, want 0", div_by_zero); end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000}, 1'b1);
    wait_done(n, nb, ch);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n < 0) begin errors++; $display("FAIL div_signed_zero_timeout: no done, want done"); end
  endtask

  task automatic test_ignore_busy;
    int n, nb; bit ch;
    issue(2'b01, 32'd3, 32'd5, {1'b0, 32'd0, 32'd15}, 1'b1);
    repeat (8) @(posedge clock);
    #1;
    op = 2'b01; read_data_1 = 32'd1000; read_data_2 = 32'd1000; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    hi_we = 1'b1; write_data = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    hi_we = 1'b0;
    wait_done(n, nb, ch);
    checks++;
    if (n < 0) begin errors++; $display("FAIL ignore_busy_timeout: no done, want done"); end
    checks++;
    if (ch) begin errors++; $display("FAIL ignore_busy_hi_we: hi/lo changed while busy, want unchanged"); end
    repeat (40) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_restart: busy=%0d, want 0", busy); end
  endtask

  task automatic test_mthi_mtlo;
    int n, nb; bit ch;
    @(posedge clock); #1;
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'h1234_5678;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1234_5678, 32'h1234_5678}) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h, want 12345678 12345678", hi, lo);
    end
    lo_we = 1'b1; write_data = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1234_5678, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL mtlo_only: hi=%h lo=%h, want 12345678 a5a5a5a5", hi, lo);
    end
    hi_we = 1'b1; write_data = 32'hCAFE_BABE;
    issue(2'b01, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1'b1);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678) begin errors++; $display("FAIL start_wins: hi=%h, want 12345678", hi); end
    wait_done(n, nb, ch);
  endtask

  task automatic test_reset_abort;
    int n, nb; bit ch;
    issue(2'b11, 32'd1000, 32'd7, 65'd0, 1'b0);
    repeat (18) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++; $display("FAIL reset_abort: busy=%0d done=%0d hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    repeat (40) @(negedge clock);
    issue(2'b11, 32'd17, 32'd5, {1'b0, 32'd2, 32'd3}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL after_abort_latency: %0d edges, want 33", n - 1); end
  endtask

  task automatic test_back_to_back;
    int n, nb; bit ch;
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, {1'b0, 32'd1, 32'd0}, 1'b1);
    wait_done(n, nb, ch);
    issue(2'b11, 32'hFFFF_FFFF, 32'd10, {1'b0, 32'd5, 32'h1999_9999}, 1'b1);
    wait_done(n, nb, ch);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL back_to_back_latency: %0d edges, want 33", n - 1); end
    checks++;
    if (nb !== 33) begin errors++; $display("FAIL back_to_back_busy: %0d, want 33", nb); end
  endtask

  task automatic test_random;
    int n, nb; bit ch;
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) b = b >> $urandom_range(0, 31);
      if (i == 4) b = 32'd0;
      issue(o, a, b, model(o, a, b), 1'b1);
      wait_done(n, nb, ch);
      checks++;
      if (n !== 34) begin errors++; $display("FAIL random_latency[%0d]: %0d edges, want 33", i, n - 1); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_multu();
    test_mult_div();
    test_div_zero();
    test_ignore_busy();
    test_mthi_mtlo();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_results: %0d outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
